// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    // Which port owned the most recent grant.
    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Arbiter mode: fair round-robin, or host holding the memory for a burst.
    typedef enum logic {
        ST_RR        = 1'b0,
        ST_HOST_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// rtl/dmem_arbiter_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (CPU/host) arbiter in front of a single-port data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [CNT_W-1:0]  conflict_cnt
);

    arb_state_t state_q, state_d;
    owner_t     last_gnt_q;
    logic       cpu_rd_q;
    logic       host_rd_q;

    // Grant decision and next mode; a cycle that leaves the lock arbitrates as round-robin.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        state_d  = state_q;
        if (!reset) begin
            if ((state_q == ST_HOST_LOCK) && host_lock) begin
                host_gnt = host_req;
            end else if (cpu_req && host_req) begin
                cpu_gnt  = (last_gnt_q == OWN_HOST);
                host_gnt = (last_gnt_q == OWN_CPU);
            end else begin
                cpu_gnt  = cpu_req;
                host_gnt = host_req;
            end
            case (state_q)
                ST_RR:        if (host_gnt && host_lock) state_d = ST_HOST_LOCK;
                ST_HOST_LOCK: if (!host_lock)            state_d = ST_RR;
                default:                                 state_d = ST_RR;
            endcase
        end
    end

    // Mode, fairness pointer and pending-read flags for the one-cycle read return.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_RR;
            last_gnt_q <= OWN_HOST;
            cpu_rd_q   <= 1'b0;
            host_rd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cpu_gnt) begin
                last_gnt_q <= OWN_CPU;
            end else if (host_gnt) begin
                last_gnt_q <= OWN_HOST;
            end
            cpu_rd_q  <= cpu_gnt & ~cpu_we;
            host_rd_q <= host_gnt & ~host_we;
        end
    end

    // Memory port follows whichever requester holds the grant this cycle.
    always_comb begin
        mem_en    = cpu_gnt | host_gnt;
        mem_we    = host_gnt ? host_we : (cpu_gnt & cpu_we);
        mem_addr  = host_gnt ? host_addr : cpu_addr;
        mem_wdata = host_gnt ? host_wdata : cpu_wdata;
    end

    // A read issued just before reset must not surface while reset is held.
    always_comb begin
        cpu_rvalid  = cpu_rd_q & ~reset;
        host_rvalid = host_rd_q & ~reset;
        cpu_rdata   = mem_rdata;
        host_rdata  = mem_rdata;
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_conflict_cnt (
        .clk   (CLOCK_50),
        .clear (reset),
        .inc   (cpu_req & host_req),
        .count (conflict_cnt)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for the data-memory arbiter
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              lock;
    } op_t;

    typedef struct {
        logic              host;
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata, host_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [CNT_W-1:0]  conflict_cnt;

    always #5 CLOCK_50 = ~CLOCK_50;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_lock    (host_lock),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    logic [DATA_W-1:0] sim_mem [1<<ADDR_W];
    logic [DATA_W-1:0] ref_mem [1<<ADDR_W];

    function automatic logic [DATA_W-1:0] init_word(int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0103);
    endfunction

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            sim_mem[i] <= init_word(i);
            ref_mem[i] = init_word(i);
        end
    end

    // single-port synchronous memory
    always @(posedge CLOCK_50) begin
        if (mem_en) begin
            if (mem_we) sim_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= sim_mem[mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int resp_cnt;
    int first_cpu_cyc;
    int last_host_cyc;
    logic [15:0] gnt_hist;

    op_t  cpu_q[$];
    op_t  host_q[$];
    rsp_t sb[$];

    logic             m_init = 1'b0;
    logic             m_lock;
    logic             m_last_host;
    logic [CNT_W-1:0] m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // reference model and scoreboard, evaluated mid-cycle
    task automatic monitor_cycle();
        logic ec, eh, both, erc, erh;
        logic [DATA_W-1:0] ed;
        cyc++;
        both = cpu_req && host_req;
        ec = 1'b0;
        eh = 1'b0;
        if (!reset) begin
            if (m_lock && host_lock) begin
                eh = host_req;
            end else if (both) begin
                ec = m_last_host;
                eh = !m_last_host;
            end else begin
                ec = cpu_req;
                eh = host_req;
            end
        end
        check_eq("cpu_gnt", cpu_gnt, ec);
        check_eq("host_gnt", host_gnt, eh);
        check_eq("mem_en", mem_en, ec | eh);
        check_eq("mem_we", mem_we, eh ? host_we : (ec & cpu_we));
        if (ec | eh) check_eq("mem_addr", mem_addr, eh ? host_addr : cpu_addr);
        if ((ec & cpu_we) | (eh & host_we)) check_eq("mem_wdata", mem_wdata, eh ? host_wdata : cpu_wdata);

        erc = 1'b0;
        erh = 1'b0;
        ed  = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (!reset) begin
                erc = !sb[0].host;
                erh = sb[0].host;
                ed  = sb[0].data;
            end
            void'(sb.pop_front());
        end
        check_eq("cpu_rvalid", cpu_rvalid, erc);
        check_eq("host_rvalid", host_rvalid, erh);
        if (erc) check_eq("cpu_rdata", cpu_rdata, ed);
        if (erh) check_eq("host_rdata", host_rdata, ed);
        if (cpu_rvalid | host_rvalid) resp_cnt++;
        if (m_init) check_eq("conflict_cnt", conflict_cnt, m_cnt);

        if (ec && !cpu_we) sb.push_back('{1'b0, ref_mem[cpu_addr], cyc + 1});
        if (eh && !host_we) sb.push_back('{1'b1, ref_mem[host_addr], cyc + 1});
        if (ec && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        if (eh && host_we) ref_mem[host_addr] = host_wdata;

        if (reset) begin
            m_lock      = 1'b0;
            m_last_host = 1'b1;
            m_cnt       = '0;
            m_init      = 1'b1;
        end else begin
            if (both && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
            if (ec) m_last_host = 1'b0;
            if (eh) m_last_host = 1'b1;
            if (!m_lock && eh && host_lock) m_lock = 1'b1;
            else if (m_lock && !host_lock)  m_lock = 1'b0;
        end

        if (cpu_gnt && first_cpu_cyc < 0) first_cpu_cyc = cyc;
        if (host_gnt) last_host_cyc = cyc;
        if (cpu_gnt | host_gnt) gnt_hist = {gnt_hist[14:0], host_gnt};
    endtask

    task automatic step(input logic rst);
        @(posedge CLOCK_50);
        #1;
        reset    = rst;
        cpu_req  = (cpu_q.size() > 0);
        host_req = (host_q.size() > 0);
        if (cpu_req) begin
            cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
        end else begin
            cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        end
        if (host_req) begin
            host_we = host_q[0].we; host_addr = host_q[0].addr;
            host_wdata = host_q[0].wdata; host_lock = host_q[0].lock;
        end else begin
            host_we = 1'b0; host_addr = '0; host_wdata = '0; host_lock = 1'b0;
        end
        @(negedge CLOCK_50);
        monitor_cycle();
        if (cpu_gnt && cpu_q.size() > 0)   void'(cpu_q.pop_front());
        if (host_gnt && host_q.size() > 0) void'(host_q.pop_front());
    endtask

    task automatic run_idle(input int max_cycles);
        int n = 0;
        while ((cpu_q.size() > 0 || host_q.size() > 0 || sb.size() > 0) && n < max_cycles) begin
            step(1'b0);
            n++;
        end
        check_eq("drain_in_budget", (cpu_q.size() + host_q.size() + sb.size()), 0);
    endtask

    task automatic do_reset();
        step(1'b1);
        resp_cnt      = 0;
        gnt_hist      = '0;
        first_cpu_cyc = -1;
        last_host_cyc = -1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
        step(1'b1);
        do_reset();

        // simultaneous reads: CPU wins the first tie, host follows
        cpu_q.push_back('{1'b0, 10'd3, 32'd0, 1'b0});
        host_q.push_back('{1'b0, 10'd5, 32'd0, 1'b0});
        run_idle(20);
        check_eq("s1_resp", resp_cnt, 2);
        check_eq("s1_order", gnt_hist[1:0], 2'b01);
        check_eq("s1_conflict", conflict_cnt, 1);

        // sustained contention alternates grants
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cpu_q.push_back('{1'b0, 10'(10 + i), 32'd0, 1'b0});
            host_q.push_back('{1'b1, 10'(40 + i), 32'(32'hBEEF_0000 + i), 1'b0});
        end
        run_idle(30);
        check_eq("s2_order", gnt_hist[5:0], 6'b010101);
        check_eq("s2_conflict", conflict_cnt, 5);
        check_eq("s2_resp", resp_cnt, 3);

        // locked host burst blocks the CPU until the lock drops
        do_reset();
        for (int i = 0; i < 16; i++) host_q.push_back('{1'b1, 10'(i), 32'(i), 1'b1});
        step(1'b0);
        cpu_q.push_back('{1'b0, 10'd3, 32'd0, 1'b0});
        run_idle(40);
        check_eq("s3_cpu_after_lock", first_cpu_cyc, last_host_cyc + 1);
        for (int i = 0; i < 16; i++) check_eq("s3_mem", sim_mem[i], 32'(i));
        check_eq("s3_conflict", conflict_cnt, 15);
        check_eq("s3_resp", resp_cnt, 1);

        // read accepted right before reset never returns
        do_reset();
        cpu_q.push_back('{1'b0, 10'd8, 32'd0, 1'b0});
        step(1'b0);
        step(1'b1);
        step(1'b0);
        check_eq("s4_resp", resp_cnt, 0);
        check_eq("s4_cpu_rvalid", cpu_rvalid, 1'b0);
        check_eq("s4_conflict", conflict_cnt, 0);
        check_eq("s4_sb_empty", sb.size(), 0);

        // 19 conflict cycles saturate a 4-bit counter
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cpu_q.push_back('{1'b1, 10'(200 + i), 32'(32'hCAFE_0000 + i), 1'b0});
            host_q.push_back('{1'b0, 10'(300 + i), 32'd0, 1'b0});
        end
        run_idle(40);
        check_eq("s5_conflict_sat", conflict_cnt, 15);

        // alternating back-to-back reads return without bubbles
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cpu_q.push_back('{1'b0, 10'(100 + 2 * i), 32'd0, 1'b0});
            host_q.push_back('{1'b0, 10'(101 + 2 * i), 32'd0, 1'b0});
        end
        run_idle(30);
        check_eq("s6_resp", resp_cnt, 10);
        check_eq("s6_order", gnt_hist[9:0], 10'b0101010101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width of data memory.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter CNT_W, default 16: width of contention counter.
REQ-004 CLOCK_50  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req / cpu_we  in  1 / 1  CPU load/store request; write when cpu_we=1.
REQ-007 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU word address, store data.
REQ-008 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-009 cpu_rvalid / cpu_rdata  out  1 / DATA_W  CPU read response.
REQ-010 host_req / host_we / host_lock  in  1 / 1 / 1  host (matrix loader/readback) request, write, burst lock.
REQ-011 host_addr / host_wdata  in  ADDR_W / DATA_W  host word address, write data.
REQ-012 host_gnt  out  1  host request accepted this cycle.
REQ-013 host_rvalid / host_rdata  out  1 / DATA_W  host read response.
REQ-014 mem_en / mem_we  out  1 / 1  single-port memory enable, write enable.
REQ-015 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address, write data.
REQ-016 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-017 conflict_cnt  out  CNT_W  cycles where both requested and one was refused.

Function
REQ-018 Transfer occurs when req&gnt; gnt is combinational from current req and registered state, same cycle.
REQ-019 At most one gnt high per cycle; mem_en = cpu_gnt|host_gnt; mem_* fields muxed from granted port.
REQ-020 FSM states: RR (round-robin), HOST_LOCK.
REQ-021 RR, single requester: that requester granted.
REQ-022 RR, both requesting: grant the port not granted most recently (registered last_gnt); last_gnt updates on every grant.
REQ-023 RR -> HOST_LOCK when host_gnt & host_lock.
REQ-024 HOST_LOCK: host_gnt=host_req; cpu_gnt=0 regardless of cpu_req.
REQ-025 HOST_LOCK -> RR on first cycle host_lock=0 at the clock edge; that cycle arbitrates as RR.
REQ-026 Read response: rvalid of the owning port high exactly one cycle after an accepted read, rdata=mem_rdata; the other port's rvalid low.
REQ-027 Writes produce no rvalid.
REQ-028 rdata of a port with rvalid=0 is don't-care; bench checks only under rvalid.
REQ-029 Back-to-back reads from alternating ports each return one cycle later, no bubbles.
REQ-030 conflict_cnt increments by 1 per cycle with cpu_req&host_req (incl. CPU blocked in HOST_LOCK with cpu_req); saturates at all-ones.
REQ-031 Requesters hold req/addr/data stable until gnt; arbiter does not buffer refused requests.

Reset
REQ-032 On reset: state=RR, last_gnt=HOST (CPU wins first tie), conflict_cnt=0.
REQ-033 On reset: cpu_rvalid=host_rvalid=0 next cycle; a read accepted in the reset cycle or the cycle before yields no response.
REQ-034 While reset=1, cpu_gnt=host_gnt=mem_en=mem_we=0.

Structure
REQ-035 Shared package holds owner enum (CPU, HOST), FSM state enum, default ADDR_W/DATA_W.
REQ-036 One sub-module, sat_counter (parameterised width, inc, clear), for conflict_cnt; rest flat.

Verification
REQ-037 Post-reset, both read addr 3/addr 5 same cycle -> cpu_gnt=1; next cycle host_gnt=1; cpu_rvalid with mem[3] then host_rvalid with mem[5]; conflict_cnt=1.
REQ-038 Both hold req 6 cycles -> grants alternate C,H,C,H,C,H; conflict_cnt=5 (last cycle only one requester remains).
REQ-039 Host writes 16 words 0..15 with host_lock=1 while cpu_req=1 -> cpu_gnt=0 throughout, all 16 writes land; RR resumes cycle after host_lock drops, CPU granted.
REQ-040 CPU read addr 8 accepted, reset asserted next cycle -> cpu_rvalid stays 0; all outputs at reset values.
REQ-041 Force conflict for 2^CNT_W+3 cycles (CNT_W=4 override) -> conflict_cnt holds 15.
REQ-042 Alternating CPU read / host read every cycle for 10 cycles -> 10 responses, each one cycle after grant, correct port, matching memory content.
